// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

   localparam int WIDTH_DEFAULT = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Bit counter width; a 2-bit operand still needs a 1-bit counter.
   function automatic int cnt_bits(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);

   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: computes a - b - bin one bit per cycle, LSB first,
// with a valid/ready handshake on both the operand and result sides.
module serial_subtractor
   import serial_sub_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             bin_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             borrow_out,
   output logic             ovf
);

   localparam int             CW   = cnt_bits(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] d_sr;
   logic [CW-1:0]    cnt;
   logic             borrow;
   logic             cell_d;
   logic             cell_bout;

   full_subtractor u_cell (
      .a    (a_sr[0]),
      .b    (b_sr[0]),
      .bin  (borrow),
      .d    (cell_d),
      .bout (cell_bout)
   );

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);

   // On the last bit, a_sr[0]/b_sr[0] are the operand sign bits, so the
   // overflow flag can be formed from the cell output alongside the result.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         a_sr       <= '0;
         b_sr       <= '0;
         d_sr       <= '0;
         cnt        <= '0;
         borrow     <= 1'b0;
         diff       <= '0;
         borrow_out <= 1'b0;
         ovf        <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  a_sr   <= a_in;
                  b_sr   <= b_in;
                  borrow <= bin_in;
                  cnt    <= '0;
                  state  <= SHIFT;
               end
            end
            SHIFT: begin
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               borrow <= cell_bout;
               d_sr   <= {cell_d, d_sr[WIDTH-1:1]};
               if (cnt == LAST) begin
                  diff       <= {cell_d, d_sr[WIDTH-1:1]};
                  borrow_out <= cell_bout;
                  ovf        <= (a_sr[0] != b_sr[0]) && (cell_d != a_sr[0]);
                  state      <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH=8 using a result scoreboard.
module tb_serial_subtractor;

   localparam int W = 8;

   typedef struct {
      logic [W-1:0] d;
      logic         bo;
      logic         ov;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] a_in = '0;
   logic [W-1:0] b_in = '0;
   logic         bin_in = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] diff;
   logic         borrow_out;
   logic         ovf;

   int   errors = 0;
   int   checks = 0;
   int   cycle = 0;
   int   hs_count = 0;
   int   rel_cycle = 0;
   exp_t sb[$];

   serial_subtractor #(.WIDTH(W)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .a_in       (a_in),
      .b_in       (b_in),
      .bin_in     (bin_in),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .diff       (diff),
      .borrow_out (borrow_out),
      .ovf        (ovf)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cycle <= cycle + 1;
      if (out_valid && out_ready) hs_count <= hs_count + 1;
   end

   // Reference: widen to W+1 bits so the top bit is the unsigned borrow.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
      exp_t       e;
      logic [W:0] r;
      r    = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bi};
      e.d  = r[W-1:0];
      e.bo = r[W];
      e.ov = (a[W-1] != b[W-1]) && (r[W-1] != a[W-1]);
      return e;
   endfunction

   task automatic send_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi, output int acc);
      int n;
      n = 0;
      a_in = a;
      b_in = b;
      bin_in = bi;
      in_valid = 1'b1;
      while (!in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      checks++;
      if (!in_ready) begin
         errors++;
         $display("[TB] FAIL accept_timeout: in_ready=%0b, required 1", in_ready);
      end
      @(posedge clk); #1;
      acc = cycle;
   endtask

   task automatic collect(input int acc, output exp_t got, output int edges, output bit ok);
      int n;
      n = 0;
      while (!out_valid && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      ok     = out_valid;
      got.d  = diff;
      got.bo = borrow_out;
      got.ov = ovf;
      edges  = cycle - acc + 1;
      checks++;
      if (!ok) begin
         errors++;
         $display("[TB] FAIL result_timeout: out_valid=%0b, required 1", out_valid);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %0b, required 1", in_ready); end
      checks++;
      if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %0b, required 0", out_valid); end
      checks++;
      if (diff !== 8'h00) begin errors++; $display("[TB] FAIL reset_diff: got %02h, required 00", diff); end
      checks++;
      if (borrow_out !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got borrow=%0b ovf=%0b, required 0 0", borrow_out, ovf);
      end
      rst_n = 1'b1;
      rel_cycle = cycle;
   endtask

   task automatic test_basic();
      logic [W-1:0] ta[5]   = '{8'h05, 8'h03, 8'h00, 8'h80, 8'h7F};
      logic [W-1:0] tb[5]   = '{8'h03, 8'h05, 8'h00, 8'h01, 8'hFF};
      logic         tbin[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [W-1:0] td[5]   = '{8'h02, 8'hFE, 8'hFF, 8'h7F, 8'h80};
      logic         tbo[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
      logic         tov[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      exp_t e, got;
      int   acc, edges;
      bit   ok;
      for (int i = 0; i < 5; i++) begin
         e.d = td[i]; e.bo = tbo[i]; e.ov = tov[i];
         sb.push_back(e);
         send_op(ta[i], tb[i], tbin[i], acc);
         in_valid = 1'b0;
         if (i == 0) begin
            checks++;
            if (acc !== rel_cycle + 1) begin
               errors++;
               $display("[TB] FAIL first_accept_edge: got cycle %0d, required %0d", acc, rel_cycle + 1);
            end
         end
         collect(acc, got, edges, ok);
         if (ok && sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (got.d !== e.d) begin errors++; $display("[TB] FAIL basic_diff[%0d]: got %02h, required %02h", i, got.d, e.d); end
            checks++;
            if (got.bo !== e.bo) begin errors++; $display("[TB] FAIL basic_borrow[%0d]: got %0b, required %0b", i, got.bo, e.bo); end
            checks++;
            if (got.ov !== e.ov) begin errors++; $display("[TB] FAIL basic_ovf[%0d]: got %0b, required %0b", i, got.ov, e.ov); end
            checks++;
            if (edges !== W + 1) begin errors++; $display("[TB] FAIL basic_latency[%0d]: got %0d edges, required %0d", i, edges, W + 1); end
         end else if (ok) begin
            checks++; errors++;
            $display("[TB] FAIL basic_scoreboard[%0d]: got empty queue, required one entry", i);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_hold();
      exp_t e, got;
      int   acc, edges, h0;
      bit   ok;
      sb.push_back(model(8'h3C, 8'h5A, 1'b1));
      out_ready = 1'b0;
      send_op(8'h3C, 8'h5A, 1'b1, acc);
      collect(acc, got, edges, ok);
      e = sb.pop_front();
      for (int k = 0; k < 5; k++) begin
         in_valid = k[0];
         a_in = W'($urandom);
         @(posedge clk); #1;
         checks++;
         if (diff !== e.d || borrow_out !== e.bo || ovf !== e.ov) begin
            errors++;
            $display("[TB] FAIL hold_outputs[%0d]: got %02h/%0b/%0b, required %02h/%0b/%0b",
                     k, diff, borrow_out, ovf, e.d, e.bo, e.ov);
         end
         checks++;
         if (in_ready !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL hold_state[%0d]: got in_ready=%0b out_valid=%0b, required 0 1", k, in_ready, out_valid);
         end
      end
      in_valid = 1'b0;
      h0 = hs_count;
      out_ready = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL hold_release: got in_ready=%0b out_valid=%0b, required 1 0", in_ready, out_valid);
      end
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (hs_count !== h0 + 1) begin
         errors++;
         $display("[TB] FAIL hold_handshakes: got %0d, required %0d", hs_count - h0, 1);
      end
   endtask

   task automatic test_abort();
      exp_t e, got;
      int   acc, edges;
      bit   seen, ok;
      send_op(8'h55, 8'h0A, 1'b0, acc);
      in_valid = 1'b0;
      repeat (4) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL abort_state: got out_valid=%0b in_ready=%0b, required 0 1", out_valid, in_ready);
      end
      checks++;
      if (diff !== 8'h00 || borrow_out !== 1'b0 || ovf !== 1'b0) begin
         errors++;
         $display("[TB] FAIL abort_outputs: got %02h/%0b/%0b, required 00/0/0", diff, borrow_out, ovf);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      seen = 1'b0;
      repeat (12) begin
         @(posedge clk); #1;
         if (out_valid) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin errors++; $display("[TB] FAIL abort_no_result: got out_valid seen=1, required 0"); end
      e.d = 8'h0F; e.bo = 1'b0; e.ov = 1'b0;
      sb.push_back(e);
      send_op(8'h10, 8'h01, 1'b0, acc);
      in_valid = 1'b0;
      collect(acc, got, edges, ok);
      e = sb.pop_front();
      checks++;
      if (got.d !== e.d || got.bo !== e.bo || got.ov !== e.ov) begin
         errors++;
         $display("[TB] FAIL abort_recover: got %02h/%0b/%0b, required %02h/%0b/%0b",
                  got.d, got.bo, got.ov, e.d, e.bo, e.ov);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      exp_t         e, got;
      int           acc, acc_prev, edges;
      bit           ok;
      logic [W-1:0] a, b;
      logic         bi;
      out_ready = 1'b1;
      acc_prev = 0;
      for (int i = 0; i < 4; i++) begin
         a  = W'($urandom_range(0, 255));
         b  = W'($urandom_range(0, 255));
         bi = 1'($urandom_range(0, 1));
         sb.push_back(model(a, b, bi));
         send_op(a, b, bi, acc);
         if (i == 3) in_valid = 1'b0;
         if (i > 0) begin
            checks++;
            if (acc - acc_prev !== W + 2) begin
               errors++;
               $display("[TB] FAIL b2b_gap[%0d]: got %0d cycles, required %0d", i, acc - acc_prev, W + 2);
            end
         end
         acc_prev = acc;
         collect(acc, got, edges, ok);
         e = sb.pop_front();
         checks++;
         if (got.d !== e.d || got.bo !== e.bo || got.ov !== e.ov) begin
            errors++;
            $display("[TB] FAIL b2b_result[%0d] %02h-%02h-%0b: got %02h/%0b/%0b, required %02h/%0b/%0b",
                     i, a, b, bi, got.d, got.bo, got.ov, e.d, e.bo, e.ov);
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_hold();
      test_abort();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, required completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
